// File: rtl/core_pkg.sv
// Shared fetch-path types and constants: PC/instruction widths, the fetch
// buffer entry, and the PC-to-BRAM-word-address mapping.
package core_pkg;
  localparam int XLEN        = 64;
  localparam int IMEM_ADDR_W = 15;
  localparam int INSTR_W     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               misalign;
  } fetch_entry_t;

  // Only the word-select bits reach the BRAM, so fetch wraps at 2^(IMEM_ADDR_W+2) bytes.
  function automatic logic [IMEM_ADDR_W-1:0] pc_to_waddr(input logic [XLEN-1:0] pc);
    return pc[IMEM_ADDR_W+1:2];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer of fetch_entry_t with flush, registered head and
// occupancy count. Depth need not be a power of two.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t      mem_q [DEPTH];
  fetch_entry_t      mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, BRAM address, in-flight tracking, redirect, fetch buffer.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned redirects into a marker entry plus halt.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              FIFO_DEPTH = 3,
  parameter logic [XLEN-1:0] RST_PC     = RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  output logic                   out_misalign
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic [CW:0]     outstanding;
  logic            issue, push, pop;
  fetch_entry_t    push_data, head;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            halt_q, halt_d, mis_pend_q, mis_pend_d, redir_mis;
`endif

  always_comb begin
    outstanding   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    // Issue depends only on registered state so out_ready never reaches imem_addr.
    issue         = !redirect_valid && (outstanding < (CW+1)'(FIFO_DEPTH));
    push          = inflight_q && !redirect_valid;
    push_data     = '{pc: inflight_pc_q, instr: imem_rdata, misalign: 1'b0};
    pc_d          = issue ? pc_q + XLEN'(4) : pc_q;
    inflight_d    = issue;
    inflight_pc_d = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    redir_mis     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    halt_d        = redirect_valid ? redir_mis : halt_q;
    mis_pend_d    = redir_mis;
    if (halt_q) begin
      issue      = 1'b0;
      pc_d       = pc_q;
      inflight_d = 1'b0;
    end
    if (mis_pend_q && !redirect_valid) begin
      push      = 1'b1;
      push_data = '{pc: pc_q, instr: '0, misalign: 1'b1};
    end
    if (redirect_valid) pc_d = redirect_pc;
`else
    if (redirect_valid) pc_d = redirect_pc & ~XLEN'(3);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RST_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q     <= 1'b0;
      mis_pend_q <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      mis_pend_q <= mis_pend_d;
    end
  end
`endif

  assign pop = out_valid && out_ready;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .head_valid (out_valid),
    .count      (count)
  );

  assign imem_addr = pc_to_waddr(pc_q);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  // Without the check every pushed misalign bit is 0, so this stays low.
  assign out_misalign = head.misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a BRAM model where word i holds i.
module tb_fetch_unit;
  import core_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0]     imem_rdata;
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   out_valid, out_ready, out_misalign;
  logic [XLEN-1:0]        out_pc;
  logic [INSTR_W-1:0]     out_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= {17'b0, imem_addr};

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_pc;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_mis", out_misalign, 0);
    chk("rst_addr", imem_addr, 0);

    // startup: cycle 0 issue, cycle 2 first output
    rst_n = 1'b1;
    chk("c0_valid", out_valid, 0);
    tick(); chk("c1_valid", out_valid, 0);
    tick();
    chk("c2_valid", out_valid, 1);
    chk("c2_pc", out_pc, 0);
    chk("c2_instr", out_instr, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("seq_valid", out_valid, 1);
      chk("seq_pc", out_pc, 64'(4*k));
      chk("seq_instr", out_instr, 64'(k));
    end

    // back-pressure: head pc 16 held for 10 cycles
    tick();
    out_ready = 1'b0;
    chk("stall_pc0", out_pc, 64'h10);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 64'h10);
    end
    chk("stall_addr", imem_addr, 7);   // 3 buffered (16,20,24), pc_q = 28
    out_ready = 1'b1;
    exp_pc = 64'h10;
    for (int k = 0; k < 8; k++) begin
      chk("resume_valid", out_valid, 1);
      chk("resume_pc", out_pc, exp_pc);
      chk("resume_instr", out_instr, exp_pc >> 2);
      tick();
      exp_pc += 4;
    end

    // redirect with buffer full and a request in flight
    out_ready = 1'b0;
    tick(); tick();
    chk("pre_redir_pc", out_pc, 64'h30);
    redir(64'h100);
    out_ready = 1'b1;
    chk("r1_valid", out_valid, 0);
    tick(); chk("r2_valid", out_valid, 0);
    tick();
    chk("r3_valid", out_valid, 1);
    chk("r3_pc", out_pc, 64'h100);
    chk("r3_instr", out_instr, 64'h40);
    tick();
    chk("r4_pc", out_pc, 64'h104);
    chk("r4_instr", out_instr, 64'h41);

    // top-of-memory wrap
    redir(64'h1FFFC);
    chk("w1_valid", out_valid, 0);
    tick(); tick();
    chk("w3_pc", out_pc, 64'h1FFFC);
    chk("w3_instr", out_instr, 64'h7FFF);
    tick();
    chk("w4_valid", out_valid, 1);
    chk("w4_pc", out_pc, 64'h20000);
    chk("w4_instr", out_instr, 0);
    tick();
    chk("w5_pc", out_pc, 64'h20004);
    chk("w5_instr", out_instr, 1);

    // half-cycle reset pulse mid-stream
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_instr", out_instr, 0);
    chk("mrst_addr", imem_addr, 0);
    #2;
    rst_n = 1'b1;
    tick(); chk("m1_valid", out_valid, 0);
    tick();
    chk("m2_valid", out_valid, 1);
    chk("m2_pc", out_pc, 0);
    chk("m2_instr", out_instr, 0);
    tick();
    chk("m3_pc", out_pc, 4);
    chk("m3_instr", out_instr, 1);

    // misaligned redirect
    redir(64'h102);
    chk("x1_valid", out_valid, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    tick();
    chk("x2_valid", out_valid, 1);
    chk("x2_pc", out_pc, 64'h102);
    chk("x2_instr", out_instr, 0);
    chk("x2_mis", out_misalign, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("halt_valid", out_valid, 0);
    end
    redir(64'h200);
    chk("y1_valid", out_valid, 0);
    tick(); chk("y2_valid", out_valid, 0);
    tick();
    chk("y3_valid", out_valid, 1);
    chk("y3_pc", out_pc, 64'h200);
    chk("y3_instr", out_instr, 64'h80);
    chk("y3_mis", out_misalign, 0);
`else
    tick(); chk("x2_valid", out_valid, 0);
    tick();
    chk("x3_valid", out_valid, 1);
    chk("x3_pc", out_pc, 64'h100);
    chk("x3_instr", out_instr, 64'h40);
    chk("x3_mis", out_misalign, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory and the execute datapath. Owns the program counter, drives the word address of the synchronous-read instruction BRAM (one-cycle read latency), and delivers {pc, instruction} pairs to the next stage over a valid/ready handshake. A small FIFO decouples consumer back-pressure from the BRAM address path, and a redirect port restarts fetch at a new PC when a branch or jump resolves.

## Interface
- XLEN, 64, PC width in bits
- IMEM_ADDR_W, 15, BRAM word-address width (32-bit words)
- FIFO_DEPTH, 3, fetch buffer entries; 3 or more is required for one instruction per cycle
- RESET_PC, 64'h0, PC loaded on reset; must be 4-byte aligned
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  IMEM_ADDR_W  BRAM word address, always pc_q[IMEM_ADDR_W+1:2]
- imem_rdata  in  32  BRAM data for the address presented the previous cycle
- redirect_valid  in  1  restart fetch at redirect_pc this cycle
- redirect_pc  in  XLEN  new fetch PC
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  32  head instruction
- out_misalign  out  1  head is a misaligned-fetch marker, not an instruction

## Operation
- State: pc_q (next PC to issue), inflight_q plus inflight_pc_q (request issued last cycle), FIFO of {pc, instr, misalign}.
- Issue condition: count + inflight_q < FIFO_DEPTH and not halted. Depends only on registered state; out_ready never reaches imem_addr.
- On issue: inflight_q <= 1, inflight_pc_q <= pc_q, pc_q <= pc_q + 4. With no issue, pc_q holds and the BRAM re-reads the same word harmlessly.
- On inflight_q with no redirect: push {inflight_pc_q, imem_rdata, 0}.
- Pop when out_valid && out_ready. Push and pop in the same cycle are both allowed. Count changes by push minus pop.
- Redirect has priority over everything:
  - FIFO is flushed, so count is 0 next cycle.
  - The returning response this cycle is discarded.
  - Any issue this cycle is cancelled, so inflight_q <= 0.
  - pc_q <= redirect_pc.
  - A pop coinciding with the redirect still counts as a completed transfer.
- PC arithmetic is modulo 2^XLEN. The memory address wraps modulo 2^(IMEM_ADDR_W+2) bytes because only pc bits [IMEM_ADDR_W+1:2] drive imem_addr.
- Outputs come from registered FIFO head storage, with no combinational path from imem_rdata.

## Timing
- Reset values:
  - pc_q = RESET_PC, imem_addr = RESET_PC[IMEM_ADDR_W+1:2].
  - out_valid = 0, out_pc = 0, out_instr = 0, out_misalign = 0.
  - FIFO empty, inflight_q = 0, halt cleared.
- Reset asserted mid-operation clears all state immediately; in-flight data is lost.
- Cycle 0 is the first cycle with rst_n high: RESET_PC is issued. Data returns and is pushed in cycle 1. out_valid rises in cycle 2.
- Steady state: one instruction per cycle while out_ready is high, given FIFO_DEPTH of 3 or more.
- Redirect in cycle N: redirect_pc is issued in cycle N+1 and its out_valid rises in cycle N+3. out_valid may remain high during cycle N from the old head. It is low in cycles N+1 and N+2.
- FIFO full (count plus in-flight equals FIFO_DEPTH) stops issue. A held out_ready low never loses or duplicates an entry.
- out_pc, out_instr and out_misalign are stable while out_valid && !out_ready.

## Configuration
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 issues nothing.
  - In cycle N+1 it pushes {redirect_pc, 32'h0, 1'b1}, so out_valid rises in cycle N+2.
  - The unit then halts issue until the next redirect.
- Undefined:
  - redirect_pc[1:0] is forced to 0.
  - out_misalign is tied to 0 and there is no halt state.

## Structure
- core_pkg holds:
  - constants XLEN, IMEM_ADDR_W, RESET_PC and INSTR_W = 32;
  - typedef fetch_entry_t {pc, instr, misalign};
  - function pc_to_waddr.
- One sub-module, fetch_fifo. It is a parameterised synchronous FIFO of fetch_entry_t with a flush input, push/pop, registered head outputs and a count output. fetch_unit holds the PC, in-flight tracking and redirect logic.

## Test plan
- Reset release with out_ready=1 and a BRAM model holding mem[i]=i: out_valid rises in cycle 2 with pc 0 and instr 0. Then pc 4, 8, 12 follow with instr 1, 2, 3 on consecutive cycles.
- out_ready low for 10 cycles mid-stream: issue stops at FIFO_DEPTH outstanding. On release the sequence resumes with no gap, duplicate or loss.
- Redirect to 0x100 while the FIFO is full and a request is in flight: no stale entries appear. Cycle N+3 delivers pc 0x100 with instr mem[0x40].
- Redirect to 0x1FFFC (top word): the next entry is pc 0x20000 with instr mem[0], i.e. the address wraps.
- rst_n pulsed low for half a cycle mid-stream: outputs immediately take their reset values, and the cycle-2 startup sequence repeats.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102: one entry {0x102, 0, misalign=1} appears in cycle N+2, followed by silence. A redirect to 0x200 then resumes normal fetch.
